// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the MEM-stage exception arbiter: ExcCodes, cp0
// register addresses, Status/Cause bit positions and the FSM state type.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_TR  = 5'd13;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LO  = 8;
  localparam int STATUS_IM_HI  = 15;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_IP_HI   = 15;
  localparam int CAUSE_BD      = 31;

  // mem_exc_i bit positions
  localparam int EXC_BIT_SYS  = 0;
  localparam int EXC_BIT_BRK  = 1;
  localparam int EXC_BIT_RI   = 2;
  localparam int EXC_BIT_OVF  = 3;
  localparam int EXC_BIT_TRAP = 4;
  localparam int EXC_BIT_ERET = 5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic in_ds);
    return in_ds ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle of MEM/cp0/WB inputs and flush/cp0-update outputs around exc_ctrl.
interface exc_ctrl_if;
  import exc_ctrl_pkg::*;

  logic        mem_valid_i;
  logic [5:0]  mem_exc_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_ds_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        exc_we_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic        exc_bd_o;
  logic        eret_o;
  exc_state_e  dbg_state_o;

  // No back-pressure: an event sampled in IDLE with mem_valid_i=1 is always
  // taken; flush_o and exc_we_o are the only "valid" qualifiers on the outputs.
  modport slave (
    input  mem_valid_i, mem_exc_i, mem_pc_i, mem_in_ds_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o, eret_o,
    output dbg_state_o
  );

  modport master (
    output mem_valid_i, mem_exc_i, mem_pc_i, mem_in_ds_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o, eret_o,
    input  dbg_state_o
  );

endinterface

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority encoder: interrupt, sys, brk, ri, trap, ovf, eret.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic       int_i,
  input  logic [5:0] exc_i,
  output logic       hit_o,
  output logic [4:0] code_o,
  output logic       is_eret_o
);

  always_comb begin
    hit_o     = 1'b1;
    code_o    = EXC_INT;
    is_eret_o = 1'b0;
    if (int_i)                   code_o = EXC_INT;
    else if (exc_i[EXC_BIT_SYS])  code_o = EXC_SYS;
    else if (exc_i[EXC_BIT_BRK])  code_o = EXC_BP;
    else if (exc_i[EXC_BIT_RI])   code_o = EXC_RI;
    else if (exc_i[EXC_BIT_TRAP]) code_o = EXC_TR;
    else if (exc_i[EXC_BIT_OVF])  code_o = EXC_OV;
    else if (exc_i[EXC_BIT_ERET]) is_eret_o = 1'b1;
    else                          hit_o = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt arbiter: bypasses WB mtc0 writes, picks one
// event, and drives a registered multi-cycle flush plus a cp0 update strobe.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [31:0] status_eff;
  logic [31:0] epc_eff;
  logic [7:0]  ip_eff;
  logic        int_pend;
  logic        hit;
  logic [4:0]  code;
  logic        is_eret;
  logic        unused_bits;

  always_comb begin
    status_eff = bus.cp0_status_i;
    epc_eff    = bus.cp0_epc_i;
    ip_eff     = bus.cp0_cause_i[CAUSE_IP_HI:CAUSE_IP_LO];
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == CP0_REG_STATUS) status_eff = bus.wb_cp0_data_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == CP0_REG_EPC)    epc_eff    = bus.wb_cp0_data_i;
    // Only the software-interrupt bits of Cause are writable by mtc0.
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == CP0_REG_CAUSE)  ip_eff[1:0] = bus.wb_cp0_data_i[9:8];
  end

  assign int_pend = (|(status_eff[STATUS_IM_HI:STATUS_IM_LO] & ip_eff))
                    && status_eff[STATUS_IE] && !status_eff[STATUS_EXL];

  assign unused_bits = ^{bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0],
                         status_eff[31:16], status_eff[7:2]};

  exc_prio u_prio (
    .int_i     (int_pend),
    .exc_i     (bus.mem_exc_i),
    .hit_o     (hit),
    .code_o    (code),
    .is_eret_o (is_eret)
  );

  exc_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic        exc_we_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_epc_q;
  logic        exc_bd_q;
  logic        eret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      new_pc_q   <= '0;
      exc_we_q   <= 1'b0;
      exc_code_q <= '0;
      exc_epc_q  <= '0;
      exc_bd_q   <= 1'b0;
      eret_q     <= 1'b0;
    end else begin
      exc_we_q   <= 1'b0;
      exc_code_q <= '0;
      exc_epc_q  <= '0;
      exc_bd_q   <= 1'b0;
      eret_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_valid_i && hit) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= CNT_LOAD;
            flush_q  <= 1'b1;
            if (is_eret) begin
              new_pc_q <= epc_eff;
              exc_we_q <= 1'b1;
              eret_q   <= 1'b1;
            end else begin
              new_pc_q   <= EXC_VECTOR;
              // Nested exception: redirect but leave EPC/Cause untouched.
              exc_we_q   <= !status_eff[STATUS_EXL];
              exc_code_q <= code;
              exc_epc_q  <= restart_pc(bus.mem_pc_i, bus.mem_in_ds_i);
              exc_bd_q   <= bus.mem_in_ds_i;
            end
          end else begin
            flush_q  <= 1'b0;
            new_pc_q <= '0;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_q  <= ST_IDLE;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.flush_o     = flush_q;
  assign bus.new_pc_o    = new_pc_q;
  assign bus.exc_we_o    = exc_we_q;
  assign bus.exc_code_o  = exc_code_q;
  assign bus.exc_epc_o   = exc_epc_q;
  assign bus.exc_bd_o    = exc_bd_q;
  assign bus.eret_o      = eret_q;
  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: priority, delay-slot EPC, nested exceptions,
// ERET bypass, events during flush and async reset.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  exc_ctrl_if bus ();

  exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.mem_valid_i    = 1'b0;
    bus.mem_exc_i      = '0;
    bus.mem_pc_i       = '0;
    bus.mem_in_ds_i    = 1'b0;
    bus.cp0_status_i   = '0;
    bus.cp0_cause_i    = '0;
    bus.cp0_epc_i      = '0;
    bus.wb_cp0_we_i    = 1'b0;
    bus.wb_cp0_waddr_i = '0;
    bus.wb_cp0_data_i  = '0;
  endtask

  task automatic drive_inst(input logic [5:0] exc, input logic [31:0] pc, input logic ds);
    bus.mem_valid_i = 1'b1;
    bus.mem_exc_i   = exc;
    bus.mem_pc_i    = pc;
    bus.mem_in_ds_i = ds;
  endtask

  task automatic check_event(input string tag, input logic we, input logic [4:0] code,
                             input logic [31:0] epc, input logic bd, input logic eret,
                             input logic [31:0] npc);
    check_val({tag, ".flush"}, 32'(bus.flush_o), 32'd1);
    check_val({tag, ".new_pc"}, bus.new_pc_o, npc);
    check_val({tag, ".we"}, 32'(bus.exc_we_o), 32'(we));
    check_val({tag, ".code"}, 32'(bus.exc_code_o), 32'(code));
    check_val({tag, ".epc"}, bus.exc_epc_o, epc);
    check_val({tag, ".bd"}, 32'(bus.exc_bd_o), 32'(bd));
    check_val({tag, ".eret"}, 32'(bus.eret_o), 32'(eret));
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, ".flush"}, 32'(bus.flush_o), 32'd0);
    check_val({tag, ".we"}, 32'(bus.exc_we_o), 32'd0);
    check_val({tag, ".new_pc"}, bus.new_pc_o, 32'd0);
    check_val({tag, ".state"}, 32'(bus.dbg_state_o), 32'(ST_IDLE));
  endtask

  // Sample one event at the next edge, check it, then let the 2-cycle flush finish.
  task automatic run_event(input string tag, input logic [5:0] exc, input logic [31:0] pc,
                           input logic ds, input logic we, input logic [4:0] code,
                           input logic [31:0] epc, input logic bd);
    @(negedge clk);
    drive_inst(exc, pc, ds);
    @(negedge clk);
    drive_idle();
    check_event(tag, we, code, epc, bd, 1'b0, 32'h20);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive_idle();
    rst = 1'b0;
    #12;
    check_quiet("reset");
    check_val("reset.code", 32'(bus.exc_code_o), 32'd0);
    check_val("reset.epc", bus.exc_epc_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: syscall, 2-cycle flush, 1-cycle strobe
    @(negedge clk);
    drive_inst(6'b000001, 32'h100, 1'b0);
    @(negedge clk);
    drive_idle();
    check_event("sys", 1'b1, EXC_SYS, 32'h100, 1'b0, 1'b0, 32'h20);
    @(negedge clk);
    check_val("sys.flush2", 32'(bus.flush_o), 32'd1);
    check_val("sys.new_pc2", bus.new_pc_o, 32'h20);
    check_val("sys.we2", 32'(bus.exc_we_o), 32'd0);
    @(negedge clk);
    check_quiet("sys.end");

    // 2: delay-slot overflow, pc wrap, trap beats ovf, brk beats ri
    run_event("ovf_ds", 6'b001000, 32'h204, 1'b1, 1'b1, EXC_OV, 32'h200, 1'b1);
    run_event("ovf_pc0", 6'b001000, 32'h0, 1'b1, 1'b1, EXC_OV, 32'hFFFF_FFFC, 1'b1);
    run_event("tr_ov", 6'b111000, 32'h208, 1'b0, 1'b1, EXC_TR, 32'h208, 1'b0);
    run_event("bp_ri", 6'b100110, 32'h20C, 1'b0, 1'b1, EXC_BP, 32'h20C, 1'b0);

    // 3: interrupt beats ri; with EXL set, ri is taken without a cp0 update
    @(negedge clk);
    bus.cp0_status_i = 32'h0000_0401;
    bus.cp0_cause_i  = 32'h0000_0400;
    drive_inst(6'b000100, 32'h300, 1'b0);
    @(negedge clk);
    drive_idle();
    check_event("int", 1'b1, EXC_INT, 32'h300, 1'b0, 1'b0, 32'h20);
    @(negedge clk);
    @(negedge clk);
    bus.cp0_status_i = 32'h0000_0403;
    bus.cp0_cause_i  = 32'h0000_0400;
    drive_inst(6'b000100, 32'h304, 1'b0);
    @(negedge clk);
    drive_idle();
    check_event("exl_ri", 1'b0, EXC_RI, 32'h304, 1'b0, 1'b0, 32'h20);
    @(negedge clk);
    @(negedge clk);

    // interrupt raised only through a bypassed WB write of Cause.IP0
    @(negedge clk);
    bus.cp0_status_i   = 32'h0000_0101;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = CP0_REG_CAUSE;
    bus.wb_cp0_data_i  = 32'h0000_0100;
    drive_inst(6'b000000, 32'h310, 1'b0);
    @(negedge clk);
    drive_idle();
    check_event("int_byp", 1'b1, EXC_INT, 32'h310, 1'b0, 1'b0, 32'h20);
    @(negedge clk);
    @(negedge clk);

    // 4: ERET with same-cycle WB write of EPC
    @(negedge clk);
    bus.cp0_epc_i      = 32'h40;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = CP0_REG_EPC;
    bus.wb_cp0_data_i  = 32'h80;
    drive_inst(6'b100000, 32'h400, 1'b1);
    @(negedge clk);
    drive_idle();
    check_event("eret", 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h80);
    @(negedge clk);
    check_val("eret.new_pc2", bus.new_pc_o, 32'h80);
    @(negedge clk);

    // 5: sys held during flush is ignored, then taken on the first IDLE cycle
    @(negedge clk);
    drive_inst(6'b000001, 32'h500, 1'b0);
    @(negedge clk);
    check_event("bb1", 1'b1, EXC_SYS, 32'h500, 1'b0, 1'b0, 32'h20);
    drive_inst(6'b000001, 32'h504, 1'b0);
    @(negedge clk);
    check_val("bb.flush2", 32'(bus.flush_o), 32'd1);
    check_val("bb.we2", 32'(bus.exc_we_o), 32'd0);
    @(negedge clk);
    check_val("bb.flush3", 32'(bus.flush_o), 32'd0);
    check_val("bb.we3", 32'(bus.exc_we_o), 32'd0);
    drive_inst(6'b000001, 32'h600, 1'b0);
    @(negedge clk);
    drive_idle();
    check_event("bb2", 1'b1, EXC_SYS, 32'h600, 1'b0, 1'b0, 32'h20);
    @(negedge clk);
    @(negedge clk);

    // 6: async reset mid-flush, then invalid instruction hides a pending interrupt
    @(negedge clk);
    drive_inst(6'b000010, 32'h700, 1'b0);
    @(negedge clk);
    drive_idle();
    check_event("pre_rst", 1'b1, EXC_BP, 32'h700, 1'b0, 1'b0, 32'h20);
    #2 rst = 1'b0;
    #1;
    check_quiet("async_rst");
    check_val("async_rst.code", 32'(bus.exc_code_o), 32'd0);
    check_val("async_rst.epc", bus.exc_epc_o, 32'd0);
    check_val("async_rst.bd", 32'(bus.exc_bd_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.cp0_status_i = 32'h0000_0401;
    bus.cp0_cause_i  = 32'h0000_0400;
    bus.mem_valid_i  = 1'b0;
    @(negedge clk);
    check_quiet("novalid");
    bus.mem_valid_i = 1'b1;
    bus.mem_pc_i    = 32'h800;
    @(negedge clk);
    drive_idle();
    check_event("int_late", 1'b1, EXC_INT, 32'h800, 1'b0, 1'b0, 32'h20);
    @(negedge clk);
    @(negedge clk);
    check_quiet("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt arbiter in the MEM stage, directly downstream of cp0.
- Consumes cp0 status/cause/epc plus per-instruction exception flags from MEM. Picks the single highest-priority event and drives a registered pipeline flush with a redirect PC.
- Issues a one-cycle exception-update strobe (EPC, ExcCode, BD, EXL set/clear) back to cp0.
- Forwards in-flight WB-stage mtc0 writes, so decisions never use stale cp0 values.

Parameters:
- EXC_VECTOR, 32'h0000_0020: handler entry PC for every non-ERET event.
- FLUSH_CYCLES, 2: cycles flush_o stays high per event (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- mem_valid_i  in  1  MEM holds a real instruction this cycle
- mem_exc_i  in  6  flags {eret, trap, ovf, ri, brk, sys}, bit5..bit0
- mem_pc_i  in  32  PC of the MEM instruction
- mem_in_ds_i  in  1  MEM instruction is in a branch delay slot
- cp0_status_i  in  32  cp0 Status
- cp0_cause_i  in  32  cp0 Cause
- cp0_epc_i  in  32  cp0 EPC
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable
- wb_cp0_waddr_i  in  5  WB mtc0 target register
- wb_cp0_data_i  in  32  WB mtc0 data
- flush_o  out  1  flush IF..MEM
- new_pc_o  out  32  redirect PC, valid while flush_o=1
- exc_we_o  out  1  one-cycle cp0 exception-update strobe
- exc_code_o  out  5  Cause.ExcCode value
- exc_epc_o  out  32  EPC value
- exc_bd_o  out  1  Cause.BD value
- eret_o  out  1  with exc_we_o: clear Status.EXL instead of setting it

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, every output 0.
- Bypass: effective Status = wb_cp0_data_i if wb_cp0_we_i and waddr=12, else cp0_status_i. Effective EPC likewise with waddr=14. Effective Cause bits[9:8] come from WB data if waddr=13; all other Cause bits come from cp0_cause_i.
- Interrupt pending = |(Status[15:8] & Cause[15:8]) && Status[0] (IE) && !Status[1] (EXL).
- Events are evaluated only in IDLE with mem_valid_i=1. Priority, highest first:
  - interrupt: code 0
  - sys: code 8
  - brk: code 9
  - ri: code 10
  - trap: code 13
  - ovf: code 12
  - eret
- Lower-priority flags set in the same cycle are dropped.
- Non-ERET event, registered on the next clk edge:
  - flush_o=1, new_pc_o=EXC_VECTOR, exc_we_o=1, eret_o=0, exc_code_o=code.
  - exc_bd_o=mem_in_ds_i.
  - exc_epc_o = mem_pc_i-4 if in delay slot, else mem_pc_i (32-bit modulo; pc=0 in delay slot gives 32'hFFFF_FFFC).
  - If effective Status.EXL=1 already: flush and redirect still occur, but exc_we_o=0, so EPC is preserved.
- ERET: flush_o=1, new_pc_o=effective EPC, exc_we_o=1, eret_o=1, exc_code_o=0, exc_epc_o=0, exc_bd_o=0.
- Latency: 1 cycle from the MEM sample to flush_o/exc_we_o.
- exc_we_o is high for exactly 1 cycle per event.
- FSM:
  - IDLE to FLUSH on any accepted event; counter loads FLUSH_CYCLES-1.
  - FLUSH holds flush_o=1 and new_pc_o stable, decrementing each cycle. FLUSH to IDLE when the counter is 0 and flush_o drops the same edge.
  - FLUSH_CYCLES=1 therefore gives a single-cycle flush.
- Inputs are ignored in FLUSH (the instructions are being squashed). Back-to-back events are accepted only from the first IDLE cycle.
- mem_valid_i=0 suppresses everything, including a pending interrupt; the interrupt waits for the next valid instruction.
- Reset asserted mid-FLUSH returns to IDLE immediately, all outputs 0.

Decomposition:
- Shared defines file holds:
  - ExcCode constants (EXC_INT/SYS/BP/RI/OV/TR).
  - cp0 register addresses 12/13/14 (the existing CP0_REG_* names).
  - Status bit indices IE=0, EXL=1, IM=15:8.
  - Cause bit indices IP=15:8, BD=31.
- Sub-module exc_prio: combinational priority encoder from {int, mem_exc_i} to {hit, code, is_eret}. The FSM, bypass and registers stay in exc_ctrl.

Test Plan:
1. Syscall: mem_exc_i=6'b000001, pc=0x100, not in delay slot -> next cycle flush_o=1, new_pc_o=0x20, exc_we_o=1, code=8, exc_epc_o=0x100, bd=0. flush_o stays 2 cycles; exc_we_o stays 1 cycle.
2. Delay-slot overflow: ovf, pc=0x204, in_ds=1 -> code=12, exc_epc_o=0x200, bd=1.
3. Interrupt plus RI: Status=0x0000_0401, Cause IP2 set, ri also set -> code=0 wins; with Status.EXL=1 instead, code=10 and flush occurs, but exc_we_o stays 0.
4. ERET with bypass: cp0_epc_i=0x40, same-cycle WB mtc0 of EPC=0x80 -> new_pc_o=0x80, eret_o=1, exc_we_o=1.
5. Event during FLUSH: a sys flag one cycle after an accepted event -> ignored, no second exc_we_o. A sys flag on the first IDLE cycle -> accepted.
6. Async reset: rst=0 asserted mid-FLUSH, between clock edges -> flush_o and all outputs 0 immediately. After release, mem_valid_i=0 with a pending interrupt -> no event.
